gmii_rx_framer: RTL and testbench

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

---
 rtl/eth_rx_pkg.sv | 31 +++
 rtl/crc32_d8.sv | 21 ++
 rtl/gmii_rx_framer.sv | 174 +++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive path: FSM states, CRC-32
// parameters, preamble/SFD bytes and delay-line geometry.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

  // CRC-32 (IEEE 802.3); the reflected form drives the LSB-first update.
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // The delay line is one byte deeper than the FCS so that the last payload
  // byte is still held when dv falls and can be tagged as eof.
  localparam int DLY_DEPTH = 5;
  localparam int FCS_LEN   = 4;
  localparam int LEN_W     = 11;

  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] l);
    return (&l) ? l : l + 1'b1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next state for one byte, reflected/LSB-first.
// Latency: 0 cycles (pure logic). Backpressure: none.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD/FCS, flags length (and CRC under GMII_RX_CRC_CHK_EN) errors.
// Latency: payload byte i appears the cycle after byte i+5 is sampled; eof the cycle after dv falls.
// Backpressure: none -- GMII cannot be stalled, every output is a registered single-cycle pulse.
module gmii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [10:0] out_len,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  localparam logic [LEN_W-1:0] MIN_L    = MIN_LEN[LEN_W-1:0];
  localparam logic [LEN_W-1:0] MAX_L    = MAX_LEN[LEN_W-1:0];
  localparam logic [LEN_W-1:0] FCS_L    = FCS_LEN[LEN_W-1:0];
  localparam logic [2:0]       DLY_FULL = DLY_DEPTH[2:0];

  rx_state_e        state, state_nxt;
  logic             frame_start;
  logic             byte_push;
  logic             frame_close;
  logic             frame_abort;

  logic [7:0]       dly [DLY_DEPTH];
  logic [2:0]       dly_cnt;
  logic [LEN_W-1:0] len;
  logic             sof_pend;
  logic             len_bad;
  logic             crc_bad;
  logic             frame_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    byte_push   = 1'b0;
    frame_close = 1'b0;
    frame_abort = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) state_nxt = (gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_nxt   = IDLE;
          frame_abort = 1'b1;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_nxt   = DATA;
          frame_start = 1'b1;
        end else if (gmii_rxd != PREAMBLE_BYTE) begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (gmii_rx_dv) begin
          byte_push = 1'b1;
        end else begin
          frame_close = 1'b1;
          state_nxt   = IDLE;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) begin
          state_nxt   = IDLE;
          frame_abort = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GMII_RX_CRC_CHK_EN
  logic [31:0] crc;
  logic [31:0] crc_nxt;

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc),
    .data    (gmii_rxd),
    .crc_out (crc_nxt)
  );

  // Running over the FCS too leaves the fixed residue on a clean frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           crc <= CRC_INIT;
    else if (frame_start) crc <= CRC_INIT;
    else if (byte_push)   crc <= crc_nxt;
  end

  assign crc_bad = (crc != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  assign len_bad   = (len < MIN_L) || (len > MAX_L);
  assign frame_bad = len_bad || crc_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY_DEPTH; i++) dly[i] <= 8'h00;
      dly_cnt       <= 3'd0;
      len           <= '0;
      sof_pend      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= 8'h00;
      out_sof       <= 1'b0;
      out_eof       <= 1'b0;
      out_err       <= 1'b0;
      out_len       <= '0;
      frame_ok_cnt  <= 16'h0000;
      frame_err_cnt <= 16'h0000;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;

      if (frame_start) begin
        dly_cnt  <= 3'd0;
        len      <= '0;
        sof_pend <= 1'b1;
      end

      if (byte_push) begin
        dly[0] <= gmii_rxd;
        for (int i = 1; i < DLY_DEPTH; i++) dly[i] <= dly[i-1];
        len <= len_sat_inc(len);
        if (dly_cnt == DLY_FULL) begin
          out_valid <= 1'b1;
          out_data  <= dly[DLY_DEPTH-1];
          out_sof   <= sof_pend;
          sof_pend  <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt + 3'd1;
        end
      end

      // The four youngest held bytes are the FCS and are simply dropped.
      if (frame_close) begin
        dly_cnt  <= 3'd0;
        sof_pend <= 1'b0;
        if (dly_cnt == DLY_FULL) begin
          out_valid <= 1'b1;
          out_data  <= dly[DLY_DEPTH-1];
          out_sof   <= sof_pend;
          out_eof   <= 1'b1;
          out_err   <= frame_bad;
          out_len   <= len - FCS_L;
          if (frame_bad) frame_err_cnt <= frame_err_cnt + 16'd1;
          else           frame_ok_cnt  <= frame_ok_cnt + 16'd1;
        end else begin
          frame_err_cnt <= frame_err_cnt + 16'd1;
        end
      end

      if (frame_abort) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: good/bad-FCS, runt, preamble error, back-to-back and reset-mid-frame cases.
module tb_gmii_rx_framer;

`ifdef GMII_RX_CRC_CHK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        out_valid, out_sof, out_eof, out_err;
  logic [7:0]  out_data;
  logic [10:0] out_len;
  logic [15:0] frame_ok_cnt, frame_err_cnt;

  always #4 clk = ~clk;

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rxd      (gmii_rxd),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_err       (out_err),
    .out_len       (out_len),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] fb[$];
  int sof_cnt = 0, eof_cnt = 0, sof_pos_bad = 0, len_mism = 0, stray = 0, both_cnt = 0;
  int frame_base = 0;
  logic        last_err = 1'b0;
  logic [10:0] last_len = '0;
  int exp_ok = 0, exp_err = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      if (out_sof) begin
        sof_cnt++;
        if (rx_q.size() != frame_base) sof_pos_bad++;
      end
      rx_q.push_back(out_data);
      if (out_eof) begin
        eof_cnt++;
        last_len = out_len;
        last_err = out_err;
        if (int'(out_len) != rx_q.size() - frame_base) len_mism++;
        if (out_sof) both_cnt++;
        frame_base = rx_q.size();
      end
    end else if (out_sof || out_eof || out_err) begin
      stray++;
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build_frame(input int npay, input logic bad_fcs, input int seed);
    logic [31:0] crc, fcs;
    logic [7:0]  b;
    fb.delete();
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      b = 8'(i * 7 + 3 + seed);
      fb.push_back(b);
      exp_q.push_back(b);
      crc = crc_upd(crc, b);
    end
    fcs = ~crc;
    for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
    if (bad_fcs) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
  endtask

  task automatic drive_fb(input int gap);
    for (int i = 0; i < fb.size(); i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fb[i];
    end
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    sof_cnt = 0; eof_cnt = 0; sof_pos_bad = 0; len_mism = 0;
    stray = 0; both_cnt = 0; frame_base = 0;
  endtask

  task automatic check_rx(input string tag, input int nsof, input int neof);
    int bad_bytes;
    bad_bytes = 0;
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad_bytes++;
    chk({tag, "_data"}, bad_bytes, 0);
    chk({tag, "_sof"}, sof_cnt, nsof);
    chk({tag, "_eof"}, eof_cnt, neof);
    chk({tag, "_sofpos"}, sof_pos_bad, 0);
    chk({tag, "_lenq"}, len_mism, 0);
    chk({tag, "_stray"}, stray, 0);
    chk({tag, "_okcnt"}, frame_ok_cnt, exp_ok);
    chk({tag, "_errcnt"}, frame_err_cnt, exp_err);
  endtask

  initial begin
    #20;
    chk("rst_valid", out_valid, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_eof", out_eof, 0);
    chk("rst_err", out_err, 0);
    chk("rst_len", out_len, 0);
    chk("rst_data", out_data, 0);
    chk("rst_okcnt", frame_ok_cnt, 0);
    chk("rst_errcnt", frame_err_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 60-byte payload, L=64, good FCS
    clear_mon();
    build_frame(60, 1'b0, 0);
    drive_fb(4);
    exp_ok++;
    check_rx("good", 1, 1);
    chk("good_len", last_len, 60);
    chk("good_errflag", last_err, 0);

    // Same frame, last FCS byte corrupted
    clear_mon();
    build_frame(60, 1'b1, 0);
    drive_fb(4);
    exp_err += int'(CRC_ON);
    exp_ok  += 1 - int'(CRC_ON);
    check_rx("badfcs", 1, 1);
    chk("badfcs_errflag", last_err, CRC_ON);
    chk("badfcs_len", last_len, 60);

    // Preamble broken by 0xAA
    clear_mon();
    fb = '{8'h55, 8'h55, 8'hAA, 8'h10, 8'h20, 8'h30, 8'h55};
    drive_fb(4);
    exp_err++;
    check_rx("prebad", 0, 0);

    // dv falls while still in preamble
    clear_mon();
    fb = '{8'h55, 8'h55, 8'h55};
    drive_fb(4);
    exp_err++;
    check_rx("predv", 0, 0);

    // Runt: L=20
    clear_mon();
    build_frame(16, 1'b0, 5);
    drive_fb(4);
    exp_err++;
    check_rx("runt", 1, 1);
    chk("runt_len", last_len, 16);
    chk("runt_errflag", last_err, 1);

    // L=5: single byte carrying both sof and eof
    clear_mon();
    build_frame(1, 1'b0, 9);
    drive_fb(4);
    exp_err++;
    check_rx("l5", 1, 1);
    chk("l5_both", both_cnt, 1);
    chk("l5_len", last_len, 1);
    chk("l5_errflag", last_err, 1);

    // Two good frames with a single idle cycle between
    clear_mon();
    build_frame(60, 1'b0, 1);
    drive_fb(1);
    build_frame(60, 1'b0, 2);
    drive_fb(4);
    exp_ok += 2;
    check_rx("b2b", 2, 2);
    chk("b2b_errflag", last_err, 0);

    // Reset pulse at payload byte 30
    build_frame(60, 1'b0, 0);
    for (int i = 0; i <= 8 + 30; i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fb[i];
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_okcnt", frame_ok_cnt, 0);
    chk("mrst_errcnt", frame_err_cnt, 0);
    clear_mon();
    exp_ok = 0;
    exp_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 8 + 32; i < fb.size(); i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fb[i];
    end
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    repeat (3) @(posedge clk);
    exp_err++;
    exp_q.delete();
    check_rx("mrst_drop", 0, 0);

    clear_mon();
    build_frame(60, 1'b0, 3);
    drive_fb(4);
    exp_ok++;
    check_rx("mrst_next", 1, 1);
    chk("mrst_next_len", last_len, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
